// File: rtl/fixed_linear_weight_source_pkg.sv
// Shared types and helpers for the fixed linear weight source.
package fixed_linear_weight_source_pkg;

  // Streaming controller states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_e;

  // Counter/address width for n values, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fixed_linear_weight_source_unpacked_fifo2.sv
// unpacked_fifo2: two-entry FIFO of SIZE-element unpacked words.
// When empty, a pushed word is presented on the output in the same cycle
// (fall-through) and is only stored if the consumer does not take it.
module unpacked_fifo2 #(
  parameter int WIDTH = 16,
  parameter int SIZE  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data [SIZE],
  output logic [1:0]       count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data  [SIZE]
);

  logic [WIDTH-1:0] mem_q [2][SIZE];
  logic [WIDTH-1:0] mem_d [2][SIZE];
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             empty, store, drain;

  // Output selection (stored head or fall-through) and next storage state.
  always_comb begin
    empty     = (count_q == 2'd0);
    out_valid = !empty || push;
    drain     = !empty && out_ready;
    store     = push && !(empty && out_ready);
    for (int k = 0; k < SIZE; k++) begin
      out_data[k] = '0;
      if (!empty)    out_data[k] = mem_q[rd_ptr_q][k];
      else if (push) out_data[k] = push_data[k];
    end
    mem_d = mem_q;
    if (store) begin
      for (int k = 0; k < SIZE; k++) mem_d[wr_ptr_q][k] = push_data[k];
    end
    wr_ptr_d = wr_ptr_q ^ store;
    rd_ptr_d = rd_ptr_q ^ drain;
    count_d  = count_q + {1'b0, store} - {1'b0, drain};
    count    = count_q;
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++)
        for (int k = 0; k < SIZE; k++) mem_q[i][k] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fixed_linear_weight_source.sv
// fixed_linear_weight_source: replays a tiled weight matrix REPEAT times from
// a single-port memory (1-cycle read latency) as a valid/ready tile stream.
// Optional feature macro: FIXED_LINEAR_WEIGHT_SOURCE_LAST_EN adds weight_last,
// marking the final tile of each pass.
module fixed_linear_weight_source
  import fixed_linear_weight_source_pkg::*;
#(
  parameter  int WEIGHT_PRECISION_0       = 16,
  parameter  int WEIGHT_TENSOR_SIZE_DIM_0 = 20,
  parameter  int WEIGHT_TENSOR_SIZE_DIM_1 = 20,
  parameter  int WEIGHT_PARALLELISM_DIM_0 = 4,
  parameter  int WEIGHT_PARALLELISM_DIM_1 = 4,
  parameter  int REPEAT                   = 5,
  localparam int DEPTH_DIM_0 = WEIGHT_TENSOR_SIZE_DIM_0 / WEIGHT_PARALLELISM_DIM_0,
  localparam int DEPTH_DIM_1 = WEIGHT_TENSOR_SIZE_DIM_1 / WEIGHT_PARALLELISM_DIM_1,
  localparam int NUM_TILES   = DEPTH_DIM_0 * DEPTH_DIM_1,
  localparam int ADDR_WIDTH  = clog2_min1(NUM_TILES),
  localparam int TILE_SIZE   = WEIGHT_PARALLELISM_DIM_0 * WEIGHT_PARALLELISM_DIM_1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    start,
  output logic                                    busy,
  output logic                                    done,
  output logic                                    mem_rd_en,
  output logic [ADDR_WIDTH-1:0]                   mem_rd_addr,
  input  logic [TILE_SIZE*WEIGHT_PRECISION_0-1:0] mem_rd_data,
  output logic [WEIGHT_PRECISION_0-1:0]           weight [TILE_SIZE],
  output logic                                    weight_valid,
`ifdef FIXED_LINEAR_WEIGHT_SOURCE_LAST_EN
  output logic                                    weight_last,
`endif
  input  logic                                    weight_ready
);

  localparam int XW = clog2_min1(DEPTH_DIM_0);
  localparam int YW = clog2_min1(DEPTH_DIM_1);
  localparam int PW = clog2_min1(REPEAT);

  state_e                        state_q, state_d;
  logic [XW-1:0]                 tile_x_q, tile_x_d;
  logic [YW-1:0]                 tile_y_q, tile_y_d;
  logic [PW-1:0]                 pass_q, pass_d;
  logic                          inflight_q, inflight_d;
  logic [1:0]                    fifo_count;
  logic                          pop, room;
  logic                          x_last, y_last, p_last;
  logic [WEIGHT_PRECISION_0-1:0] rd_tile [TILE_SIZE];

  // Controller: start acceptance, read issue with credit check, tile walk
  // (x fastest, then y, then pass) and drain-to-done.
  always_comb begin
    state_d    = state_q;
    tile_x_d   = tile_x_q;
    tile_y_d   = tile_y_q;
    pass_d     = pass_q;
    busy       = 1'b0;
    done       = 1'b0;
    mem_rd_en  = 1'b0;
    pop        = weight_valid && weight_ready;
    // Stored words plus the word in flight, minus what leaves now, must
    // leave a free slot for the read issued this cycle.
    room       = (int'(fifo_count) + int'(inflight_q) - int'(pop)) < 2;
    x_last     = (tile_x_q == XW'(DEPTH_DIM_0 - 1));
    y_last     = (tile_y_q == YW'(DEPTH_DIM_1 - 1));
    p_last     = (pass_q   == PW'(REPEAT - 1));
    case (state_q)
      IDLE: begin
        tile_x_d = '0;
        tile_y_d = '0;
        pass_d   = '0;
        if (start) state_d = STREAM;
      end
      STREAM: begin
        busy      = 1'b1;
        mem_rd_en = room;
        if (room) begin
          if (!x_last) begin
            tile_x_d = tile_x_q + XW'(1);
          end else begin
            tile_x_d = '0;
            if (!y_last) begin
              tile_y_d = tile_y_q + YW'(1);
            end else begin
              tile_y_d = '0;
              if (!p_last) begin
                pass_d = pass_q + PW'(1);
              end else begin
                pass_d  = '0;
                state_d = DRAIN;
              end
            end
          end
        end
      end
      DRAIN: begin
        if (fifo_count == 2'd0 && !inflight_q) begin
          done    = 1'b1;
          state_d = IDLE;
        end else begin
          busy = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    inflight_d = mem_rd_en;
  end

  // Row-major tile address from the walk counters.
  always_comb begin
    mem_rd_addr = ADDR_WIDTH'(tile_y_q) * ADDR_WIDTH'(DEPTH_DIM_0) + ADDR_WIDTH'(tile_x_q);
  end

  // Split the packed memory word into elements, element k at bits [k*W +: W].
  always_comb begin
    for (int k = 0; k < TILE_SIZE; k++)
      rd_tile[k] = mem_rd_data[k*WEIGHT_PRECISION_0 +: WEIGHT_PRECISION_0];
  end

  // Controller state, walk counters and the read-in-flight marker.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      tile_x_q   <= '0;
      tile_y_q   <= '0;
      pass_q     <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tile_x_q   <= tile_x_d;
      tile_y_q   <= tile_y_d;
      pass_q     <= pass_d;
      inflight_q <= inflight_d;
    end
  end

  // Returning read data is pushed the cycle it arrives; a read in flight
  // across reset is dropped because inflight_q is cleared.
  unpacked_fifo2 #(
    .WIDTH (WEIGHT_PRECISION_0),
    .SIZE  (TILE_SIZE)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data (rd_tile),
    .count     (fifo_count),
    .out_valid (weight_valid),
    .out_ready (weight_ready),
    .out_data  (weight)
  );

`ifdef FIXED_LINEAR_WEIGHT_SOURCE_LAST_EN
  logic       last_inflight_q, last_inflight_d;
  logic       last_in [1];
  logic       last_out [1];
  logic [1:0] last_count;
  logic       last_valid;

  // Tag the read of the final tile of a pass; it lands alongside its data.
  always_comb begin
    last_inflight_d = mem_rd_en && x_last && y_last;
    last_in[0]      = last_inflight_q;
    weight_last     = last_valid && last_out[0] && (last_count <= 2'd2);
  end

  // Tag delay matching the memory read latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_inflight_q <= 1'b0;
    else      last_inflight_q <= last_inflight_d;
  end

  // Shadow FIFO with identical push/pop so the tag stays aligned with its tile.
  unpacked_fifo2 #(
    .WIDTH (1),
    .SIZE  (1)
  ) u_last_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data (last_in),
    .count     (last_count),
    .out_valid (last_valid),
    .out_ready (weight_ready),
    .out_data  (last_out)
  );
`endif

endmodule

// File: tb/tb_fixed_linear_weight_source.sv
// Bench for fixed_linear_weight_source: 4x4 matrix / 2x2 tiles / REPEAT=2,
// plus a single-tile instance (REPEAT=3). Expected stream: for each pass,
// tiles 0..NUM_TILES-1 in order, element k of tile a = 16'hA000 + a*16 + k.
module tb_fixed_linear_weight_source;
  localparam int TS = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0, ready = 1'b0;
  logic o_start = 1'b0, o_ready = 1'b0;
  logic rand_mode = 1'b0;
  always #5 clk = ~clk;

  logic        busy, done, rd_en, wvalid;
  logic [1:0]  rd_addr;
  logic [63:0] rd_data = '0;
  logic [15:0] weight [TS];
  logic        o_busy, o_done, o_rd_en, o_wvalid;
  logic [0:0]  o_rd_addr;
  logic [63:0] o_rd_data = '0;
  logic [15:0] o_weight [TS];
`ifdef FIXED_LINEAR_WEIGHT_SOURCE_LAST_EN
  logic wlast, o_wlast;
`endif

  fixed_linear_weight_source #(
    .WEIGHT_PRECISION_0(16), .WEIGHT_TENSOR_SIZE_DIM_0(4), .WEIGHT_TENSOR_SIZE_DIM_1(4),
    .WEIGHT_PARALLELISM_DIM_0(2), .WEIGHT_PARALLELISM_DIM_1(2), .REPEAT(2)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .mem_rd_en(rd_en), .mem_rd_addr(rd_addr), .mem_rd_data(rd_data),
    .weight(weight), .weight_valid(wvalid),
`ifdef FIXED_LINEAR_WEIGHT_SOURCE_LAST_EN
    .weight_last(wlast),
`endif
    .weight_ready(ready)
  );

  fixed_linear_weight_source #(
    .WEIGHT_PRECISION_0(16), .WEIGHT_TENSOR_SIZE_DIM_0(2), .WEIGHT_TENSOR_SIZE_DIM_1(2),
    .WEIGHT_PARALLELISM_DIM_0(2), .WEIGHT_PARALLELISM_DIM_1(2), .REPEAT(3)
  ) u_one (
    .clk(clk), .rst(rst), .start(o_start), .busy(o_busy), .done(o_done),
    .mem_rd_en(o_rd_en), .mem_rd_addr(o_rd_addr), .mem_rd_data(o_rd_data),
    .weight(o_weight), .weight_valid(o_wvalid),
`ifdef FIXED_LINEAR_WEIGHT_SOURCE_LAST_EN
    .weight_last(o_wlast),
`endif
    .weight_ready(o_ready)
  );

  function automatic logic [15:0] elem(input int a, input int k);
    return 16'(32'hA000 + a * 16 + k);
  endfunction

  function automatic logic [63:0] pack_tile(input int a);
    logic [63:0] t;
    for (int k = 0; k < TS; k++) t[k*16 +: 16] = elem(a, k);
    return t;
  endfunction

  // Memory models: data valid one cycle after the read strobe.
  always @(posedge clk) if (rd_en)   rd_data   <= pack_tile(int'(rd_addr));
  always @(posedge clk) if (o_rd_en) o_rd_data <= pack_tile(int'(o_rd_addr));

  int checks = 0, failures = 0, cyc = 0;
  int issue_n, beat_n, done_n, first_valid_cyc, last_pop_cyc, done_cyc;
  int issue_addr [16];
  int issue_cyc [16];
  logic [15:0] beat0_w [TS];
  logic [15:0] beat5_w [TS];
  logic [15:0] prev_w [TS];
  logic prev_stall = 1'b0;
  int o_issue_n = 0, o_beat_n = 0, o_done_n = 0;

  always @(posedge clk) cyc++;
  always @(posedge clk) begin
    #2;
    if (rand_mode) ready = 1'($urandom_range(0, 1));
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison of both instances against the stream model.
  always @(negedge clk) begin
    if (!rst) begin
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_rd_en", rd_en, 0);
      check("rst_rd_addr", rd_addr, 0);
      check("rst_valid", wvalid, 0);
      for (int k = 0; k < TS; k++) check("rst_weight", weight[k], 0);
`ifdef FIXED_LINEAR_WEIGHT_SOURCE_LAST_EN
      check("rst_last", wlast, 0);
`endif
      prev_stall = 1'b0;
    end else begin
      if (rd_en) begin
        check("rd_addr_order", rd_addr, issue_n % 4);
        check("busy_on_read", busy, 1);
        if (issue_n < 16) begin
          issue_addr[issue_n] = int'(rd_addr);
          issue_cyc[issue_n]  = cyc;
        end
        issue_n++;
      end
      if (prev_stall) begin
        check("stall_valid_held", wvalid, 1);
        for (int k = 0; k < TS; k++) check("stall_data_held", weight[k], prev_w[k]);
      end
      if (wvalid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (wvalid && ready) begin
        for (int k = 0; k < TS; k++) check("beat_data", weight[k], elem(beat_n % 4, k));
`ifdef FIXED_LINEAR_WEIGHT_SOURCE_LAST_EN
        check("beat_last", wlast, (beat_n % 4) == 3);
`endif
        if (beat_n == 0) beat0_w = weight;
        if (beat_n == 5) beat5_w = weight;
        beat_n++;
        last_pop_cyc = cyc;
      end
      check("done_timing", done, (beat_n == 8) && (last_pop_cyc == cyc - 1));
      if (done) begin
        check("busy_low_at_done", busy, 0);
        done_n++;
        done_cyc = cyc;
      end
      prev_stall = wvalid && !ready;
      prev_w = weight;

      if (o_rd_en) begin
        check("one_addr", o_rd_addr, 0);
        o_issue_n++;
      end
      if (o_wvalid && o_ready) begin
        for (int k = 0; k < TS; k++) check("one_data", o_weight[k], elem(0, k));
`ifdef FIXED_LINEAR_WEIGHT_SOURCE_LAST_EN
        check("one_last", o_wlast, 1);
`endif
        o_beat_n++;
      end
      if (o_done) o_done_n++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_sb();
    issue_n = 0; beat_n = 0; done_n = 0;
    first_valid_cyc = -1; last_pop_cyc = -10; done_cyc = -1;
  endtask

  task automatic pulse_start(output int c);
    c = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int n = 0;
    while (done_n == 0 && n < budget) begin
      tick();
      n++;
    end
    check({nm, "_done_seen"}, done_n != 0, 1);
  endtask

  initial begin
    int c, n;
    int exp_addr [8];
    exp_addr = '{0, 1, 2, 3, 0, 1, 2, 3};
    clear_sb();

    // Reset, then basic pass with ready held high.
    repeat (3) tick();
    rst = 1'b1;
    tick();
    ready = 1'b1;
    pulse_start(c);
    check("t1_busy_after_start", busy, 1);
    wait_done("t1", 100);
    check("t1_issues", issue_n, 8);
    check("t1_beats", beat_n, 8);
    check("t1_done_count", done_n, 1);
    for (int i = 0; i < 8; i++) begin
      check("t1_addr_seq", issue_addr[i], exp_addr[i]);
      check("t1_addr_cycle", issue_cyc[i], c + 1 + i);
    end
    check("t1_first_valid", first_valid_cyc, c + 2);
    check("t1_last_pop", last_pop_cyc, c + 9);
    check("t1_done_cycle", done_cyc, c + 10);
    check("t1_beat0_e3", beat0_w[3], 16'hA003);
    check("t1_beat5_e0", beat5_w[0], 16'hA010);
    tick();
    check("t1_idle_busy", busy, 0);

    // Random backpressure.
    clear_sb();
    rand_mode = 1'b1;
    pulse_start(c);
    wait_done("t2", 300);
    check("t2_issues", issue_n, 8);
    check("t2_beats", beat_n, 8);
    check("t2_done_count", done_n, 1);

    // Start mid-stream and on the done cycle are both ignored.
    clear_sb();
    pulse_start(c);
    repeat (3) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!done && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("t3_done_seen", done, 1);
    start = 1'b1;
    rand_mode = 1'b0;
    tick();
    start = 1'b0;
    ready = 1'b1;
    repeat (4) begin
      check("t3_no_restart_rd", rd_en, 0);
      check("t3_no_restart_busy", busy, 0);
      tick();
    end
    check("t3_issues", issue_n, 8);
    check("t3_beats", beat_n, 8);

    // Reset after the third beat, then restart from address 0.
    clear_sb();
    pulse_start(c);
    n = 0;
    while (beat_n < 3 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("t4_three_beats", beat_n, 3);
    rst = 1'b0;
    #1;
    check("t4_async_busy", busy, 0);
    check("t4_async_valid", wvalid, 0);
    check("t4_async_rd_en", rd_en, 0);
    check("t4_async_addr", rd_addr, 0);
    for (int k = 0; k < TS; k++) check("t4_async_weight", weight[k], 0);
    repeat (2) tick();
    rst = 1'b1;
    repeat (3) begin
      tick();
      check("t4_post_rst_valid", wvalid, 0);
      check("t4_post_rst_rd_en", rd_en, 0);
    end
    clear_sb();
    pulse_start(c);
    wait_done("t4", 100);
    check("t4_first_addr", issue_addr[0], 0);
    check("t4_first_issue_cycle", issue_cyc[0], c + 1);
    check("t4_beats", beat_n, 8);

    // Single-tile matrix, three passes.
    o_ready = 1'b1;
    o_start = 1'b1;
    tick();
    o_start = 1'b0;
    n = 0;
    while (o_done_n == 0 && n < 50) begin
      tick();
      n++;
    end
    check("t5_done_seen", o_done_n != 0, 1);
    check("t5_issues", o_issue_n, 3);
    check("t5_beats", o_beat_n, 3);
    check("t5_busy_after", o_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
